// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//   NUM_CH independent programmable clock dividers / tick generators.
//   Each channel produces a divided square wave, a one-cycle tick on the last
//   cycle of every period and, in one-shot mode, a one-cycle done pulse.
//   Divisor and mode are written into a shadow copy and only become active at
//   a period boundary (or immediately when an idle one-shot channel advances).
//
// Ports
//   clock_in     in   1       system clock
//   reset_n      in   1       asynchronous active-low reset
//   enable       in   1       global advance; low freezes all channel state
//   cfg_we       in   1       configuration write strobe (honoured regardless
//                             of enable)
//   cfg_ch       in   CH_W    target channel of the write
//   cfg_div      in   CNT_W   new period in clock_in cycles (>= 2)
//   cfg_oneshot  in   1       1 = one-shot mode, 0 = continuous
//   start        in   NUM_CH  per-channel one-shot trigger
//   clock_out    out  NUM_CH  divided square wave (high floor(div/2) cycles)
//   tick         out  NUM_CH  one-cycle pulse on the last cycle of a period
//   done         out  NUM_CH  tick of a one-shot period
//   cfg_err      out  1       one-cycle pulse after a rejected write
// -----------------------------------------------------------------------------
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50_000_000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] start,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] done,
  output logic              cfg_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    LP_NUM_CH      = (CH_W + 1)'(NUM_CH);

  // A write is only accepted for an existing channel and a divisor of 2 or
  // more; the channel index is widened so non-power-of-two banks reject the
  // unused encodings.
  logic w_cfg_ok;
  assign w_cfg_ok = (cfg_div >= CNT_W'(2)) && ({1'b0, cfg_ch} < LP_NUM_CH);

  logic r_cfg_err;
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_cfg_err <= cfg_we && !w_cfg_ok;
    end
  end
  assign cfg_err = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Active configuration and counter
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div;
    logic             r_oneshot;
    state_t           r_state;
    // Shadow configuration
    logic [CNT_W-1:0] r_sh_div;
    logic             r_sh_oneshot;
    logic             r_pend;
    // Registered outputs
    logic             r_clk;
    logic             r_tick;
    logic             r_done;

    logic             w_wr;
    logic [CNT_W-1:0] w_sh_div_eff;
    logic             w_sh_os_eff;
    logic             w_pend_eff;
    logic [CNT_W-1:0] w_count_n;
    logic [CNT_W-1:0] w_div_n;
    logic             w_os_n;
    state_t           w_state_n;
    logic             w_pend_n;
    logic             w_tick_n;
    logic             w_clk_n;
    logic             w_done_n;

    always_comb begin
      // NOTE: every signal gets a default before any branch so the block is
      // purely combinational and no latch is inferred.
      w_wr         = cfg_we && w_cfg_ok && (cfg_ch == CH_W'(g));
      // A write landing on the apply edge itself is folded in directly, so
      // the last write always wins even on the wrap edge.
      w_sh_div_eff = w_wr ? cfg_div     : r_sh_div;
      w_sh_os_eff  = w_wr ? cfg_oneshot : r_sh_oneshot;
      w_pend_eff   = w_wr || r_pend;
      w_count_n    = r_count;
      w_div_n      = r_div;
      w_os_n       = r_oneshot;
      w_state_n    = r_state;
      w_pend_n     = w_pend_eff;

      unique case (r_state)
        ST_RUN: begin
          if (r_count == r_div - CNT_W'(1)) begin
            w_count_n = '0;
            if (w_pend_eff) begin
              w_div_n  = w_sh_div_eff;
              w_os_n   = w_sh_os_eff;
              w_pend_n = 1'b0;
            end
            // A one-shot period ends here; a channel switched to one-shot at
            // this wrap also lands in IDLE.
            w_state_n = w_os_n ? ST_IDLE : ST_RUN;
          end else begin
            w_count_n = r_count + CNT_W'(1);
          end
        end
        default: begin
          w_count_n = '0;
          if (w_pend_eff) begin
            w_div_n  = w_sh_div_eff;
            w_os_n   = w_sh_os_eff;
            w_pend_n = 1'b0;
          end
          // Leaving IDLE either by trigger or by a switch to continuous mode;
          // the first running cycle is count 0.
          if (!w_os_n || start[g]) begin
            w_state_n = ST_RUN;
          end
        end
      endcase

      w_tick_n = (w_state_n == ST_RUN) && (w_count_n == w_div_n - CNT_W'(1));
      w_clk_n  = (w_state_n == ST_RUN) && (w_count_n < (w_div_n >> 1));
      w_done_n = w_tick_n && w_os_n;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: the shadow copy and pending flag are reset along with the
        // active state so a write in flight at reset is discarded.
        r_count      <= '0;
        r_div        <= LP_DEFAULT_DIV;
        r_oneshot    <= 1'b0;
        r_state      <= ST_RUN;
        r_sh_div     <= LP_DEFAULT_DIV;
        r_sh_oneshot <= 1'b0;
        r_pend       <= 1'b0;
        r_clk        <= 1'b0;
        r_tick       <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        r_sh_div     <= w_sh_div_eff;
        r_sh_oneshot <= w_sh_os_eff;
        if (enable) begin
          r_count   <= w_count_n;
          r_div     <= w_div_n;
          r_oneshot <= w_os_n;
          r_state   <= w_state_n;
          r_pend    <= w_pend_n;
          r_clk     <= w_clk_n;
          r_tick    <= w_tick_n;
          r_done    <= w_done_n;
        end else begin
          // Writes still land in the shadow while frozen; nothing is applied.
          r_pend <= w_pend_eff;
        end
      end
    end

    assign clock_out[g] = r_clk;
    assign tick[g]      = r_tick;
    assign done[g]      = r_done;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//   Directed bench for clk_div_bank with 3 channels and a reset divisor of 4.
//   Expected per-cycle outputs are queued before each clock edge and compared
//   one cycle later, just after the edge.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 26;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;

  logic              clock_in = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] done;
  logic              cfg_err;

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .CH_W        (CH_W)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .clock_out   (clock_out),
    .tick        (tick),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clock_in = ~clock_in;

  // ch < 0 selects a cfg_err comparison, otherwise the channel outputs.
  typedef struct {
    string tag;
    int    ch;
    logic  clk;
    logic  tck;
    logic  dn;
    logic  err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_edges  = 0;

  task automatic push_ch(input string tag, input int ch, input logic clk,
                         input logic tck, input logic dn);
    exp_t e;
    e.tag = tag; e.ch = ch; e.clk = clk; e.tck = tck; e.dn = dn; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_err(input string tag, input logic err);
    exp_t e;
    e.tag = tag; e.ch = -1; e.clk = 1'b0; e.tck = 1'b0; e.dn = 1'b0; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.ch < 0) begin
        n_checks++;
        assert (cfg_err === e.err) else begin
          n_errors++;
          $error("FAIL %s cfg_err: got %b expected %b", e.tag, cfg_err, e.err);
        end
      end else begin
        n_checks++;
        assert (clock_out[e.ch] === e.clk) else begin
          n_errors++;
          $error("FAIL %s ch%0d clock_out: got %b expected %b", e.tag, e.ch,
                 clock_out[e.ch], e.clk);
        end
        n_checks++;
        assert (tick[e.ch] === e.tck) else begin
          n_errors++;
          $error("FAIL %s ch%0d tick: got %b expected %b", e.tag, e.ch,
                 tick[e.ch], e.tck);
        end
        n_checks++;
        assert (done[e.ch] === e.dn) else begin
          n_errors++;
          $error("FAIL %s ch%0d done: got %b expected %b", e.tag, e.ch,
                 done[e.ch], e.dn);
        end
      end
    end
  endtask

  // One clock edge; strobes are single-cycle, results compared 1 time unit
  // after the edge.
  task automatic cyc();
    @(posedge clock_in);
    #1;
    n_edges++;
    cfg_we = 1'b0;
    start  = '0;
    drain();
  endtask

  task automatic wr(input int ch, input int div, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = CH_W'(ch);
    cfg_div     = CNT_W'(div);
    cfg_oneshot = os;
  endtask

  // n running cycles of a channel whose count after the previous edge is c.
  // Setting c to div-1 beforehand means "the next edge starts a new period".
  task automatic run_cont(input string tag, input int ch, input int div,
                          input logic os, input int n, inout int c);
    for (int i = 0; i < n; i++) begin
      c = (c + 1) % div;
      push_ch(tag, ch, c < div / 2, c == div - 1, (c == div - 1) && os);
      cyc();
    end
  endtask

  task automatic idle(input string tag, input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      push_ch(tag, ch, 1'b0, 1'b0, 1'b0);
      cyc();
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, e0, e1, k;

    reset_n     = 1'b1;
    enable      = 1'b0;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_div     = '0;
    cfg_oneshot = 1'b0;
    start       = '0;
    #2 reset_n  = 1'b0;
    @(posedge clock_in);
    @(posedge clock_in);
    #1;

    // Reset state
    for (int ch = 0; ch < NUM_CH; ch++) push_ch("reset", ch, 1'b0, 1'b0, 1'b0);
    push_err("reset", 1'b0);
    drain();

    reset_n = 1'b1;
    enable  = 1'b1;

    // Continuous div=4 from reset: 1,0,0,1,1,0,0,... with tick at count 3
    c0 = 0;
    run_cont("cont_div4", 0, 4, 1'b0, 12, c0);

    // div=5 written mid-period on ch0: current div=4 period completes first
    wr(0, 5, 1'b0);
    push_err("valid_wr", 1'b0);
    run_cont("div4_tail", 0, 4, 1'b0, 3, c0);
    c0 = 4;
    run_cont("div5", 0, 5, 1'b0, 10, c0);

    // div=2 written on the wrap edge itself takes effect at that wrap
    wr(0, 2, 1'b0);
    c0 = 1;
    run_cont("div2", 0, 2, 1'b0, 6, c0);
    e0 = n_edges;

    // Shadow write on ch1: two writes in one period, the last one wins
    c1 = n_edges % 4;
    k  = (1 - c1 + 4) % 4;
    run_cont("ch1_pre", 1, 4, 1'b0, k, c1);
    wr(1, 6, 1'b0);
    run_cont("shadow_tail", 1, 4, 1'b0, 2, c1);
    c1 = 5;
    run_cont("div6", 1, 6, 1'b0, 12, c1);
    run_cont("div6b", 1, 6, 1'b0, 2, c1);
    wr(1, 7, 1'b0);
    run_cont("div6c", 1, 6, 1'b0, 1, c1);
    wr(1, 8, 1'b0);
    run_cont("div6d", 1, 6, 1'b0, 3, c1);
    c1 = 7;
    run_cont("div8", 1, 8, 1'b0, 8, c1);
    e1 = n_edges;

    // ch2 to one-shot div=10: applied at its next wrap, then IDLE
    c2 = n_edges % 4;
    wr(2, 10, 1'b1);
    k = (3 - c2 + 4) % 4;
    run_cont("ch2_to_os", 2, 4, 1'b0, k, c2);
    idle("os_idle", 2, 3);

    // One-shot run: second start while running is ignored
    start[2] = 1'b1;
    c2 = 9;
    run_cont("os_run", 2, 10, 1'b1, 1, c2);
    start[2] = 1'b1;
    run_cont("os_restart_ignored", 2, 10, 1'b1, 1, c2);
    run_cont("os_run_end", 2, 10, 1'b1, 8, c2);
    idle("os_done_idle", 2, 3);

    // Rejected writes leave ch0 at div=2
    c0 = (c0 + n_edges - e0) % 2;
    wr(0, 1, 1'b0);
    push_err("err_div1", 1'b1);
    run_cont("err_div1_ch0", 0, 2, 1'b0, 1, c0);
    push_err("err_div1_clear", 1'b0);
    run_cont("err_div1_ch0b", 0, 2, 1'b0, 1, c0);
    wr(NUM_CH, 5, 1'b0);
    push_err("err_ch", 1'b1);
    run_cont("err_ch_ch0", 0, 2, 1'b0, 1, c0);
    push_err("err_ch_clear", 1'b0);
    run_cont("err_keep_div2", 0, 2, 1'b0, 6, c0);

    // enable low 7 cycles on ch1 mid-period: outputs frozen, period stretched
    c1 = (c1 + n_edges - e1) % 8;
    k  = (2 - c1 + 8) % 8;
    run_cont("pre_hold", 1, 8, 1'b0, k, c1);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        wr(0, 0, 1'b0);
        push_err("err_while_hold", 1'b1);
      end
      if (i == 1) push_err("err_while_hold_clear", 1'b0);
      push_ch("hold", 1, c1 < 4, c1 == 7, 1'b0);
      cyc();
    end
    enable = 1'b1;
    run_cont("stretch", 1, 8, 1'b0, 14, c1);

    // Reset during a one-shot run with a pending write
    start[2] = 1'b1;
    c2 = 9;
    run_cont("os_pre_reset", 2, 10, 1'b1, 3, c2);
    wr(2, 20, 1'b0);
    run_cont("os_pend", 2, 10, 1'b1, 1, c2);
    #2 reset_n = 1'b0;
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) push_ch("async_reset", ch, 1'b0, 1'b0, 1'b0);
    push_err("async_reset", 1'b0);
    drain();
    #1 reset_n = 1'b1;
    c2 = 0;
    run_cont("post_reset_div4", 2, 4, 1'b0, 9, c2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
